// File: rtl/byte_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// byte_scan_ctrl_pkg
// Shared definitions for the byte scan controller and its serial detector:
//   - ctrl_state_e : controller states (IDLE, SHIFT, FLUSH, REPORT)
//   - S0..S7       : detector Moore state codes
//   - PAT_1111/PAT_1001 : the two 4-bit patterns the detector reports
//   - det_is_match : decodes the detector states whose suffix is a full match
// -----------------------------------------------------------------------------
package byte_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_REPORT = 2'd3
  } ctrl_state_e;

  // Each detector state names the longest suffix of the bit history that is
  // still a prefix of one of the two patterns.
  localparam logic [2:0] S0 = 3'd0;  // no useful suffix (cleared history)
  localparam logic [2:0] S1 = 3'd1;  // "1"
  localparam logic [2:0] S2 = 3'd2;  // "11"
  localparam logic [2:0] S3 = 3'd3;  // "111"
  localparam logic [2:0] S4 = 3'd4;  // "1111"  -> match
  localparam logic [2:0] S5 = 3'd5;  // "10"
  localparam logic [2:0] S6 = 3'd6;  // "100"
  localparam logic [2:0] S7 = 3'd7;  // "1001"  -> match

  localparam logic [3:0] PAT_1111 = 4'b1111;
  localparam logic [3:0] PAT_1001 = 4'b1001;

  // States S4 and S7 are exactly the states reached after PAT_1111 / PAT_1001.
  function automatic logic det_is_match(input logic [2:0] s);
    return (s == S4) || (s == S7);
  endfunction

endpackage

// File: rtl/byte_scan_ctrl_seq_detect8.sv
// -----------------------------------------------------------------------------
// seq_detect8
// 8-state serial Moore detector. z is 1 when the last four bits applied since
// the last history clear are 1111 or 1001 (overlapping matches count).
// Ports:
//   Clock  : rising-edge clock
//   Resetn : asynchronous active-low reset (history cleared)
//   clr    : synchronous history clear (takes priority over adv)
//   adv    : advance the detector by one bit
//   w      : serial input bit
//   z      : registered match flag, reflects a bit one cycle after it is applied
// -----------------------------------------------------------------------------
module seq_detect8
  import byte_scan_ctrl_pkg::*;
(
  input  logic Clock,
  input  logic Resetn,
  input  logic clr,
  input  logic adv,
  input  logic w,
  output logic z
);

  logic [2:0] state_r;
  logic [2:0] next_s;
  logic       z_r;

  // Next-state function of the Moore detector (longest-suffix tracking).
  always_comb begin
    next_s = S0;
    case (state_r)
      S0:      if (w) next_s = S1; else next_s = S0;
      S1:      if (w) next_s = S2; else next_s = S5;
      S2:      if (w) next_s = S3; else next_s = S5;
      S3:      if (w) next_s = S4; else next_s = S5;
      S4:      if (w) next_s = S4; else next_s = S5;  // 11111 keeps matching
      S5:      if (w) next_s = S1; else next_s = S6;  // 101 -> suffix "1"
      S6:      if (w) next_s = S7; else next_s = S0;
      S7:      if (w) next_s = S2; else next_s = S5;  // 10011 -> "11", 10010 -> "10"
      default: next_s = S0;
    endcase
  end

  // State register; z is registered from the next state so it is a pure
  // function of the current state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= S0;
      z_r     <= 1'b0;
    end else if (clr) begin
      state_r <= S0;
      z_r     <= 1'b0;
    end else if (adv) begin
      state_r <= next_s;
      z_r     <= det_is_match(next_s);
    end else begin
      state_r <= state_r;
      z_r     <= z_r;
    end
  end

  assign z = z_r;

endmodule

// File: rtl/byte_scan_ctrl.sv
// -----------------------------------------------------------------------------
// byte_scan_ctrl
// Accepts a word on a valid/ready handshake, feeds it MSB-first through
// seq_detect8 one bit per clock, counts the detector hits attributed to the
// word and returns the count on a second valid/ready handshake.
// Ports:
//   Clock, Resetn          : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready : input word handshake
//   keep_ctx               : at accept, 1 keeps detector history, 0 clears it
//   out_hits/out_last_hit  : result (hit count, z after the final bit)
//   out_valid/out_ready    : result handshake
//   busy                   : high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module byte_scan_ctrl
  import byte_scan_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             keep_ctx,
  output logic [CNT_W-1:0] out_hits,
  output logic             out_last_hit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  ctrl_state_e      state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [IDX_W-1:0] idx_r;
  logic [CNT_W-1:0] hit_cnt_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [CNT_W-1:0] out_hits_r;
  logic             out_last_hit_r;
  logic             busy_r;

  logic clr_s;
  logic adv_s;
  logic w_s;
  logic z_s;

  // Detector drive: clear on accept without keep_ctx, advance during SHIFT.
  always_comb begin
    clr_s = 1'b0;
    adv_s = 1'b0;
    w_s   = shreg_r[WIDTH-1];
    if (state_r == ST_IDLE) begin
      clr_s = in_valid && in_ready_r && !keep_ctx;
    end else if (state_r == ST_SHIFT) begin
      adv_s = 1'b1;
    end else begin
      clr_s = 1'b0;
      adv_s = 1'b0;
    end
  end

  seq_detect8 u_det (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr    (clr_s),
    .adv    (adv_s),
    .w      (w_s),
    .z      (z_s)
  );

  // Controller FSM with registered handshake and result outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r        <= ST_IDLE;
      shreg_r        <= '0;
      idx_r          <= '0;
      hit_cnt_r      <= '0;
      in_ready_r     <= 1'b1;
      out_valid_r    <= 1'b0;
      out_hits_r     <= '0;
      out_last_hit_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            shreg_r    <= in_data;
            idx_r      <= '0;
            hit_cnt_r  <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_SHIFT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
          // z during idx 0 still reflects the previous word's last bit.
          if ((idx_r != '0) && z_s) begin
            hit_cnt_r <= hit_cnt_r + CNT_W'(1);
          end else begin
            hit_cnt_r <= hit_cnt_r;
          end
          if (idx_r == IDX_LAST) begin
            state_r <= ST_FLUSH;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        ST_FLUSH: begin
          // Detector is idle here; z now reflects the word's final bit.
          if (z_s) begin
            hit_cnt_r  <= hit_cnt_r + CNT_W'(1);
            out_hits_r <= hit_cnt_r + CNT_W'(1);
          end else begin
            out_hits_r <= hit_cnt_r;
          end
          out_last_hit_r <= z_s;
          out_valid_r    <= 1'b1;
          state_r        <= ST_REPORT;
        end
        ST_REPORT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_REPORT;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_hits     = out_hits_r;
  assign out_last_hit = out_last_hit_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_byte_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_byte_scan_ctrl
// Directed self-checking bench for byte_scan_ctrl (WIDTH=8, CNT_W=4).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_byte_scan_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             Clock = 1'b0;
  logic             Resetn;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             keep_ctx;
  logic [CNT_W-1:0] out_hits;
  logic             out_last_hit;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int checks = 0;
  int errors = 0;

  byte_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .keep_ctx     (keep_ctx),
    .out_hits     (out_hits),
    .out_last_hit (out_last_hit),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word in IDLE, wait for its result, check it, then complete the
  // result handshake and check the return to IDLE.
  task automatic send_word(input string tag, input logic [7:0] d, input logic keep,
                           input logic [3:0] exp_hits, input logic exp_last);
    int   lat;
    logic ready_low;
    in_data  = d;
    keep_ctx = keep;
    in_valid = 1'b1;
    check({tag, "_in_ready_idle"}, in_ready, 1);
    @(negedge Clock);           // accept edge has passed: cycle 1
    in_valid  = 1'b0;
    lat       = 1;
    ready_low = 1'b1;
    while ((out_valid !== 1'b1) && (lat < 20)) begin
      if (in_ready !== 1'b0) ready_low = 1'b0;
      @(negedge Clock);
      lat++;
    end
    check({tag, "_latency"}, lat, 10);
    check({tag, "_ready_low_while_busy"}, ready_low, 1);
    check({tag, "_hits"}, out_hits, exp_hits);
    check({tag, "_last_hit"}, out_last_hit, exp_last);
    check({tag, "_busy_report"}, busy, 1);
    out_ready = 1'b1;
    @(negedge Clock);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_idle_ready"}, in_ready, 1);
    check({tag, "_hits_hold"}, out_hits, exp_hits);
  endtask

  initial begin
    int waited;
    Resetn    = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    keep_ctx  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge Clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_hits", out_hits, 0);
    check("rst_last_hit", out_last_hit, 0);
    check("rst_busy", busy, 0);
    Resetn = 1'b1;
    @(negedge Clock);

    // Main function and context handling.
    send_word("ff",        8'hFF, 1'b0, 4'd5, 1'b1);
    send_word("x99",       8'h99, 1'b0, 4'd2, 1'b1);
    send_word("x00",       8'h00, 1'b0, 4'd0, 1'b0);
    send_word("x01_a",     8'h01, 1'b0, 4'd0, 1'b0);
    send_word("x20_keep",  8'h20, 1'b1, 4'd1, 1'b0);
    send_word("x01_b",     8'h01, 1'b0, 4'd0, 1'b0);
    send_word("x20_clear", 8'h20, 1'b0, 4'd0, 1'b0);
    // With history kept after 0xFF, every bit of the next 0xFF is a hit (max).
    send_word("ff_a",      8'hFF, 1'b0, 4'd5, 1'b1);
    send_word("ff_keep",   8'hFF, 1'b1, 4'd8, 1'b1);

    // Backpressure in REPORT.
    in_data  = 8'h99;
    keep_ctx = 1'b0;
    in_valid = 1'b1;
    @(negedge Clock);
    in_valid = 1'b0;
    waited   = 1;
    while ((out_valid !== 1'b1) && (waited < 20)) begin
      @(negedge Clock);
      waited++;
    end
    check("bp_latency", waited, 10);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      in_data  = 8'hFF;
      @(negedge Clock);
      check("bp_valid_hold", out_valid, 1);
      check("bp_hits_hold", out_hits, 2);
      check("bp_in_ready_low", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge Clock);
    out_ready = 1'b0;
    check("bp_release_idle", in_ready, 1);
    check("bp_release_busy", busy, 0);
    check("bp_release_valid", out_valid, 0);
    @(negedge Clock);
    check("bp_no_late_accept", busy, 0);

    // Reset in the middle of SHIFT aborts the word.
    in_data  = 8'hFF;
    keep_ctx = 1'b0;
    in_valid = 1'b1;
    @(negedge Clock);
    in_valid = 1'b0;
    repeat (3) @(negedge Clock);
    check("abort_busy_before", busy, 1);
    Resetn = 1'b0;
    @(negedge Clock);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_hits", out_hits, 0);
    Resetn = 1'b1;
    waited = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      if (out_valid !== 1'b0) waited++;
    end
    check("abort_no_result", waited, 0);
    send_word("x99_after_abort", 8'h99, 1'b0, 4'd2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
